ctrl_decode_stage: RTL and testbench

Parametrised decode-stage controller for the MIPS pipeline. It decodes opcode/funct into the full control bundle and registers that bundle into the ID/EX boundary with a valid bit. It handles bubble insertion on flush, full-pipe freeze on external stall, load-use hazard stalls and a HALT drain sequence. It sits between the IF/ID register and the EX stage and replaces the purely combinational controller.

---
 rtl/ctrl_decode_stage_if.sv | 50 +++++
 rtl/ctrl_decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_decode_stage_if.sv
// Decode-stage bus between IF/ID, the hazard sources and the ID/EX control register.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface ctrl_decode_stage_if #(
  parameter int unsigned FBITS   = 6,
  parameter int unsigned INSBITS = 6,
  parameter int unsigned RBITS   = 5
);
  logic               i_valid;
  logic [FBITS-1:0]   i_opcode;
  logic [INSBITS-1:0] i_funct;
  logic [RBITS-1:0]   i_rs;
  logic [RBITS-1:0]   i_rt;
  logic               i_ex_mem_read;
  logic [RBITS-1:0]   i_ex_rt;
  logic               i_flush;
  logic               i_stall_ext;

  logic       o_stall;
  logic       o_valid;
  logic       o_reg_write;
  logic       o_alu_source;
  logic       o_mem_write;
  logic       o_mem_read;
  logic       o_mem_to_reg;
  logic       o_beq;
  logic       o_bne;
  logic       o_jump;
  logic       o_link;
  logic [2:0] o_alu_op;
  logic [1:0] o_reg_dst;
  logic [1:0] o_select_addr;
  logic [4:0] o_size_control;
  logic       o_halted;

  modport master (
    output i_valid, i_opcode, i_funct, i_rs, i_rt, i_ex_mem_read, i_ex_rt,
           i_flush, i_stall_ext,
    input  o_stall, o_valid, o_reg_write, o_alu_source, o_mem_write, o_mem_read,
           o_mem_to_reg, o_beq, o_bne, o_jump, o_link, o_alu_op, o_reg_dst,
           o_select_addr, o_size_control, o_halted
  );

  modport slave (
    input  i_valid, i_opcode, i_funct, i_rs, i_rt, i_ex_mem_read, i_ex_rt,
           i_flush, i_stall_ext,
    output o_stall, o_valid, o_reg_write, o_alu_source, o_mem_write, o_mem_read,
           o_mem_to_reg, o_beq, o_bne, o_jump, o_link, o_alu_op, o_reg_dst,
           o_select_addr, o_size_control, o_halted
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// MIPS decode stage: decodes opcode/funct and registers the control bundle into ID/EX.
// Define CTRL_HAZARD_DETECT_EN to enable load-use hazard detection (stall + bubble).
module ctrl_decode_stage #(
  parameter int unsigned FBITS        = 6,
  parameter int unsigned INSBITS      = 6,
  parameter int unsigned RBITS        = 5,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  ctrl_decode_stage_if.slave bus
);
  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic       alu_source;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       link;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] select_addr;
    logic [4:0] size_control;
  } ctl_t;

  logic [5:0]    op;
  logic [5:0]    fn;
  ctl_t          dec;
  ctl_t          ctl_q;
  logic          is_halt;
  logic          hazard;
  logic          halt_take;
  logic          valid_q;
  logic          halted_q;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  assign op = 6'(bus.i_opcode);
  assign fn = 6'(bus.i_funct);

  always_comb begin
    dec     = '0;
    is_halt = 1'b0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b001000: dec.select_addr = 2'b11;
          6'b001001: begin
            dec.select_addr = 2'b11;
            dec.link        = 1'b1;
            dec.reg_dst     = 2'b10;
          end
          default: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 2'b01;
          end
        endcase
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b001010: begin
        dec.reg_write  = 1'b1;
        dec.alu_source = 1'b1;
        case (op)
          6'b001000: dec.alu_op = 3'b001;
          6'b001100: dec.alu_op = 3'b010;
          6'b001101: dec.alu_op = 3'b011;
          6'b001110: dec.alu_op = 3'b100;
          6'b001111: dec.alu_op = 3'b101;
          default:   dec.alu_op = 3'b110;
        endcase
      end
      6'b000100, 6'b000101: begin
        dec.beq         = ~op[0];
        dec.bne         = op[0];
        dec.alu_op      = 3'b111;
        dec.select_addr = 2'b01;
      end
      6'b000010: begin
        dec.jump        = 1'b1;
        dec.select_addr = 2'b10;
      end
      6'b000011: begin
        dec.jump        = 1'b1;
        dec.link        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.reg_dst     = 2'b10;
        dec.select_addr = 2'b10;
      end
      // op[1:0] selects byte/half/word, op[2] marks the zero-extending load variants
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        dec.mem_read     = 1'b1;
        dec.mem_to_reg   = 1'b1;
        dec.reg_write    = 1'b1;
        dec.alu_source   = 1'b1;
        dec.alu_op       = 3'b001;
        dec.size_control = {1'b0, op[2], op[1:0] == 2'b11, op[1:0] == 2'b01, op[1:0] == 2'b00};
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.mem_write    = 1'b1;
        dec.alu_source   = 1'b1;
        dec.alu_op       = 3'b001;
        dec.size_control = {2'b00, op[1:0] == 2'b11, op[1:0] == 2'b01, op[1:0] == 2'b00};
      end
      6'b111111: is_halt = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_HAZARD_DETECT_EN
  logic reads_rt;
  assign reads_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) ||
                    (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101011);
  assign hazard = bus.i_valid && bus.i_ex_mem_read && (bus.i_ex_rt != '0) &&
                  ((bus.i_ex_rt == bus.i_rs) || ((bus.i_ex_rt == bus.i_rt) && reads_rt));
`else
  assign hazard = 1'b0;
`endif

  assign halt_take = (state == RUN) && bus.i_valid && is_halt && !bus.i_flush &&
                     !bus.i_stall_ext && !hazard;

  assign bus.o_stall = !i_reset &&
                       (bus.i_stall_ext || hazard || (state != RUN) || halt_take);

  // Every non-reset, non-frozen edge defaults to a bubble; only a clean RUN latch overrides it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctl_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      state    <= RUN;
      cnt      <= '0;
    end else if (!bus.i_stall_ext) begin
      ctl_q   <= '0;
      valid_q <= 1'b0;
      case (state)
        RUN: begin
          if (!bus.i_flush && !hazard) begin
            valid_q <= bus.i_valid;
            if (bus.i_valid) ctl_q <= dec;
            if (halt_take) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt == CW'(DRAIN_CYCLES)) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_valid        = valid_q;
  assign bus.o_halted       = halted_q;
  assign bus.o_reg_write    = ctl_q.reg_write;
  assign bus.o_alu_source   = ctl_q.alu_source;
  assign bus.o_mem_write    = ctl_q.mem_write;
  assign bus.o_mem_read     = ctl_q.mem_read;
  assign bus.o_mem_to_reg   = ctl_q.mem_to_reg;
  assign bus.o_beq          = ctl_q.beq;
  assign bus.o_bne          = ctl_q.bne;
  assign bus.o_jump         = ctl_q.jump;
  assign bus.o_link         = ctl_q.link;
  assign bus.o_alu_op       = ctl_q.alu_op;
  assign bus.o_reg_dst      = ctl_q.reg_dst;
  assign bus.o_select_addr  = ctl_q.select_addr;
  assign bus.o_size_control = ctl_q.size_control;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed vectors push expectations, a monitor checks them.
// Expected hazard behaviour follows whether CTRL_HAZARD_DETECT_EN is defined for the build.
module tb_ctrl_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_decode_stage_if #(.FBITS(6), .INSBITS(6), .RBITS(5)) bus ();

  ctrl_decode_stage #(
    .FBITS(6), .INSBITS(6), .RBITS(5), .DRAIN_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus.slave)
  );

`ifdef CTRL_HAZARD_DETECT_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  // {rw,as,mw,mr,mtr,beq,bne,jump,link}, alu_op, reg_dst, select_addr, size_control
  localparam logic [20:0] C_ZERO = '0;
  localparam logic [20:0] C_ADD  = {9'b100000000, 3'b000, 2'b01, 2'b00, 5'b00000};
  localparam logic [20:0] C_LW   = {9'b110110000, 3'b001, 2'b00, 2'b00, 5'b00100};
  localparam logic [20:0] C_LHU  = {9'b110110000, 3'b001, 2'b00, 2'b00, 5'b01010};
  localparam logic [20:0] C_LB   = {9'b110110000, 3'b001, 2'b00, 2'b00, 5'b00001};
  localparam logic [20:0] C_ADDI = {9'b110000000, 3'b001, 2'b00, 2'b00, 5'b00000};
  localparam logic [20:0] C_ORI  = {9'b110000000, 3'b011, 2'b00, 2'b00, 5'b00000};
  localparam logic [20:0] C_SW   = {9'b011000000, 3'b001, 2'b00, 2'b00, 5'b00100};
  localparam logic [20:0] C_SH   = {9'b011000000, 3'b001, 2'b00, 2'b00, 5'b00010};
  localparam logic [20:0] C_JAL  = {9'b100000011, 3'b000, 2'b10, 2'b10, 5'b00000};
  localparam logic [20:0] C_J    = {9'b000000010, 3'b000, 2'b00, 2'b10, 5'b00000};
  localparam logic [20:0] C_BEQ  = {9'b000001000, 3'b111, 2'b00, 2'b01, 5'b00000};
  localparam logic [20:0] C_BNE  = {9'b000000100, 3'b111, 2'b00, 2'b01, 5'b00000};
  localparam logic [20:0] C_JR   = {9'b000000000, 3'b000, 2'b00, 2'b11, 5'b00000};

  typedef struct {
    string       name;
    logic        stall;
    logic        valid;
    logic        halted;
    logic [20:0] ctl;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [20:0] got_ctl;
  assign got_ctl = {bus.o_reg_write, bus.o_alu_source, bus.o_mem_write, bus.o_mem_read,
                    bus.o_mem_to_reg, bus.o_beq, bus.o_bne, bus.o_jump, bus.o_link,
                    bus.o_alu_op, bus.o_reg_dst, bus.o_select_addr, bus.o_size_control};

  task automatic chk(input string nm, input string field, input logic [20:0] got,
                     input logic [20:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, field, got, want);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic vld,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic exr, input logic [4:0] ext,
                      input logic fl, input logic sx,
                      input logic es, input logic ev, input logic eh,
                      input logic [20:0] ec);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.i_valid       = vld;
    bus.i_opcode      = op;
    bus.i_funct       = fn;
    bus.i_rs          = rs;
    bus.i_rt          = rt;
    bus.i_ex_mem_read = exr;
    bus.i_ex_rt       = ext;
    bus.i_flush       = fl;
    bus.i_stall_ext   = sx;
    e.name   = nm;
    e.stall  = es;
    e.valid  = ev;
    e.halted = eh;
    e.ctl    = ec;
    sbq.push_back(e);
  endtask

  // Monitor: o_stall is checked mid-low-phase, registered outputs just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.name, "stall", 21'(bus.o_stall), 21'(e.stall));
        @(posedge clk);
        #1;
        chk(e.name, "valid", 21'(bus.o_valid), 21'(e.valid));
        chk(e.name, "halted", 21'(bus.o_halted), 21'(e.halted));
        chk(e.name, "ctl", got_ctl, e.ctl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_opcode = '0; bus.i_funct = '0; bus.i_rs = '0; bus.i_rt = '0;
    bus.i_ex_mem_read = 1'b0; bus.i_ex_rt = '0; bus.i_flush = 1'b0; bus.i_stall_ext = 1'b0;

    //   name          rst vld op         fn         rs rt exr ext fl sx  stall valid halt ctl
    step("reset0",     1, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 0, 0, C_ZERO);
    step("reset1",     1, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 0, 0, C_ZERO);
    step("add",        0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_ADD);
    step("lw",         0, 1, 6'b100011, 6'b000000, 1, 5, 0, 0, 0, 0,  0, 1, 0, C_LW);
    step("lu_rs",      0, 1, 6'b000000, 6'b100000, 5, 2, 1, 5, 0, 0,  HZ, !HZ, 0, HZ ? C_ZERO : C_ADD);
    step("lu_rt",      0, 1, 6'b000000, 6'b100000, 3, 5, 1, 5, 0, 0,  HZ, !HZ, 0, HZ ? C_ZERO : C_ADD);
    step("lu_r0",      0, 1, 6'b000000, 6'b100000, 0, 0, 1, 0, 0, 0,  0, 1, 0, C_ADD);
    step("addi_rt",    0, 1, 6'b001000, 6'b000000, 1, 5, 1, 5, 0, 0,  0, 1, 0, C_ADDI);
    step("sw_rt",      0, 1, 6'b101011, 6'b000000, 2, 5, 1, 5, 0, 0,  HZ, !HZ, 0, HZ ? C_ZERO : C_SW);
    step("sh",         0, 1, 6'b101001, 6'b000000, 2, 6, 0, 0, 0, 0,  0, 1, 0, C_SH);
    step("jal_flush",  0, 1, 6'b000011, 6'b000000, 0, 0, 0, 0, 1, 0,  0, 0, 0, C_ZERO);
    step("jal",        0, 1, 6'b000011, 6'b000000, 0, 0, 0, 0, 0, 0,  0, 1, 0, C_JAL);
    step("flush_hz",   0, 1, 6'b000000, 6'b100000, 5, 2, 1, 5, 1, 0,  HZ, 0, 0, C_ZERO);
    step("lhu",        0, 1, 6'b100101, 6'b000000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_LHU);
    step("freeze0",    0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 1,  1, 1, 0, C_LHU);
    step("freeze1",    0, 1, 6'b000010, 6'b000000, 1, 2, 0, 0, 1, 1,  1, 1, 0, C_LHU);
    step("freeze2",    0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 1,  1, 1, 0, C_LHU);
    step("lb",         0, 1, 6'b100000, 6'b000000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_LB);
    step("ori",        0, 1, 6'b001101, 6'b000000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_ORI);
    step("beq",        0, 1, 6'b000100, 6'b000000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_BEQ);
    step("bne",        0, 1, 6'b000101, 6'b000000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_BNE);
    step("j",          0, 1, 6'b000010, 6'b000000, 0, 0, 0, 0, 0, 0,  0, 1, 0, C_J);
    step("jr",         0, 1, 6'b000000, 6'b001000, 3, 0, 0, 0, 0, 0,  0, 1, 0, C_JR);
    step("unknown",    0, 1, 6'b110011, 6'b000000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_ZERO);
    step("halt_flush", 0, 1, 6'b111111, 6'b000000, 0, 0, 0, 0, 1, 0,  0, 0, 0, C_ZERO);
    step("add2",       0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_ADD);
    step("halt",       0, 1, 6'b111111, 6'b000000, 0, 0, 0, 0, 0, 0,  1, 1, 0, C_ZERO);
    step("drain1",     0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  1, 0, 0, C_ZERO);
    step("drain2",     0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 1, 0,  1, 0, 0, C_ZERO);
    step("drain3",     0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  1, 0, 0, C_ZERO);
    step("drain4",     0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  1, 0, 0, C_ZERO);
    step("halted",     0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  1, 0, 1, C_ZERO);
    step("halted_hold",0, 1, 6'b000011, 6'b000000, 1, 2, 0, 0, 1, 0,  1, 0, 1, C_ZERO);
    step("reset2",     1, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 0, 0, C_ZERO);
    step("add3",       0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_ADD);
    step("halt2",      0, 1, 6'b111111, 6'b000000, 0, 0, 0, 0, 0, 0,  1, 1, 0, C_ZERO);
    step("drain_a",    0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  1, 0, 0, C_ZERO);
    step("rst_mid",    1, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 0, 0, C_ZERO);
    step("post_rst",   0, 1, 6'b000000, 6'b100000, 1, 2, 0, 0, 0, 0,  0, 1, 0, C_ADD);

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
